// File: rtl/bench_reg_responder_if.sv
// bench_reg_responder_if
//   Register channel between the TLP transceiver (master) and the
//   application register responder (slave).
//
//   Write channel : wrAddr_in, wrData_in, wrValid_in (always accepted)
//   Read request  : rdReqAddr_in, rdReqValid_in, rdReqReady_out
//   Read response : rdRespData_out, rdRespValid_out, rdRespReady_in
//
//   Handshake rule (both read channels): a transfer happens on a rising
//   clock edge where valid and ready are both high. Once valid is raised
//   the sender holds it, and the payload, stable until that transfer;
//   ready may change freely and never waits on valid.
interface bench_reg_responder_if;
    logic [6:0]  wrAddr_in;
    logic [31:0] wrData_in;
    logic        wrValid_in;
    logic [6:0]  rdReqAddr_in;
    logic        rdReqValid_in;
    logic        rdReqReady_out;
    logic [31:0] rdRespData_out;
    logic        rdRespValid_out;
    logic        rdRespReady_in;

    modport master (
        output wrAddr_in, wrData_in, wrValid_in,
        output rdReqAddr_in, rdReqValid_in,
        input  rdReqReady_out,
        input  rdRespData_out, rdRespValid_out,
        output rdRespReady_in
    );

    modport slave (
        input  wrAddr_in, wrData_in, wrValid_in,
        input  rdReqAddr_in, rdReqValid_in,
        output rdReqReady_out,
        output rdRespData_out, rdRespValid_out,
        input  rdRespReady_in
    );
endinterface

// File: rtl/bench_reg_responder.sv
// bench_reg_responder
//   Application-side register responder for the PCIe benchmark app.
//   Serves host register writes/reads: a scratch register file, the
//   round-trip echo register at CTL_BASE-2 and the benchmark cycle timer
//   at CTL_BASE-1. Read responses sit in a one-entry output register that
//   the transceiver can back-pressure.
//
//   Ports
//     pcieClk_in       : sole clock
//     pcieRst_n_in     : asynchronous active-low reset
//     bus              : register channel (slave side of bench_reg_responder_if)
//     dmaDone_in       : one-cycle pulse from the DMA engine, stops the timer
//     timerRunning_out : timer FSM state (1 = RUN); this is the FSM state bit
module bench_reg_responder #(
    parameter int CTL_BASE    = 64,
    parameter int NUM_SCRATCH = 16
) (
    input  logic                  pcieClk_in,
    input  logic                  pcieRst_n_in,
    bench_reg_responder_if.slave  bus,
    input  logic                  dmaDone_in,
    output logic                  timerRunning_out
);
    localparam int          SW         = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
    localparam logic [6:0]  ECHO_ADDR  = 7'(CTL_BASE - 2);
    localparam logic [6:0]  TIMER_ADDR = 7'(CTL_BASE - 1);
    localparam logic [31:0] COUNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} timer_state_t;

    logic [31:0]  scratch [NUM_SCRATCH];
    logic [31:0]  echo_reg;
    logic [31:0]  timer_count;
    timer_state_t state, state_nxt;

    logic         wr_scratch, wr_echo, timer_start, timer_stop;
    logic         count_clr, count_inc;
    logic [31:0]  rd_mux_data;
    logic         rd_accept;
    logic [31:0]  resp_data;
    logic         resp_valid;

    // ---------------- write decode ----------------
    always_comb begin
        wr_scratch  = bus.wrValid_in && ({25'd0, bus.wrAddr_in} < 32'(NUM_SCRATCH));
        wr_echo     = bus.wrValid_in && (bus.wrAddr_in == ECHO_ADDR);
        timer_start = bus.wrValid_in && (bus.wrAddr_in == TIMER_ADDR) && (bus.wrData_in != 32'd0);
        timer_stop  = bus.wrValid_in && (bus.wrAddr_in == TIMER_ADDR) && (bus.wrData_in == 32'd0);
    end

    always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
        if (!pcieRst_n_in) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= 32'd0;
            echo_reg <= 32'd0;
        end else begin
            if (wr_scratch) scratch[bus.wrAddr_in[SW-1:0]] <= bus.wrData_in;
            if (wr_echo)    echo_reg <= bus.wrData_in;
        end
    end

    // ---------------- timer FSM ----------------
    always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
        if (!pcieRst_n_in) state <= IDLE;
        else               state <= state_nxt;
    end

    // A nonzero timer write beats a coincident dmaDone_in.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (timer_start) state_nxt = RUN;
            RUN: begin
                if (timer_start)                   state_nxt = RUN;
                else if (timer_stop || dmaDone_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The stopping edge itself does not count, so the frozen value is the
    // one held when the stop was sampled.
    always_comb begin
        timerRunning_out = (state == RUN);
        count_clr        = timer_start;
        count_inc        = (state == RUN) && !timer_start && !timer_stop && !dmaDone_in;
    end

    always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
        if (!pcieRst_n_in)                           timer_count <= 32'd0;
        else if (count_clr)                          timer_count <= 32'd0;
        else if (count_inc && timer_count != COUNT_MAX) timer_count <= timer_count + 32'd1;
    end

    // ---------------- read path ----------------
    // Mux reads current register contents, so a same-cycle write to the
    // same address is not visible until the following read.
    always_comb begin
        rd_mux_data = 32'd0;
        if ({25'd0, bus.rdReqAddr_in} < 32'(NUM_SCRATCH))
            rd_mux_data = scratch[bus.rdReqAddr_in[SW-1:0]];
        else if (bus.rdReqAddr_in == ECHO_ADDR)
            rd_mux_data = echo_reg;
        else if (bus.rdReqAddr_in == TIMER_ADDR)
            rd_mux_data = timer_count;
    end

    assign bus.rdReqReady_out = !resp_valid || bus.rdRespReady_in;
    assign rd_accept          = bus.rdReqValid_in && bus.rdReqReady_out;

    always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
        if (!pcieRst_n_in) begin
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
        end else if (rd_accept) begin
            resp_valid <= 1'b1;
            resp_data  <= rd_mux_data;
        end else if (bus.rdRespReady_in) begin
            resp_valid <= 1'b0;
        end
    end

    assign bus.rdRespValid_out = resp_valid;
    assign bus.rdRespData_out  = resp_data;
endmodule
